// File: rtl/spill_sequencer_pkg.sv
// Shared types and widths for the spill sequencer and its error collector.
package spill_sequencer_pkg;

   localparam int SPILL_W           = 10;
   localparam int EVT_W             = 16;
   localparam int DRAIN_CYC_DEFAULT = 256;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      LIVE,
      DRAIN,
      REPORT
   } state_e;

endpackage

// File: rtl/spill_err_collector.sv
// Per-link sticky error bits; checker flags are sampled one cycle after the package strobe.
module spill_err_collector
   import spill_sequencer_pkg::*;
#(
   parameter int NLINK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic [NLINK-1:0] sample_en_i,
   input  logic [NLINK-1:0] evt_err_i,
   input  logic [NLINK-1:0] spill_err_i,
   output logic [NLINK-1:0] evt_sticky_o,
   output logic [NLINK-1:0] spill_sticky_o
);

   logic [NLINK-1:0] en_q;
   logic [NLINK-1:0] evt_q;
   logic [NLINK-1:0] spill_q;

   // The outputs fold in the sample landing this cycle, so a reader in the
   // first REPORT cycle already sees the error from the last DRAIN package.
   assign evt_sticky_o   = evt_q   | (en_q & evt_err_i);
   assign spill_sticky_o = spill_q | (en_q & spill_err_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q    <= '0;
         evt_q   <= '0;
         spill_q <= '0;
      end else begin
         en_q <= sample_en_i;
         if (clear_i) begin
            evt_q   <= '0;
            spill_q <= '0;
         end else begin
            evt_q   <= evt_q   | (en_q & evt_err_i);
            spill_q <= spill_q | (en_q & spill_err_i);
         end
      end
   end

endmodule

// File: rtl/spill_sequencer.sv
// Spill control FSM: arms checkers on live, gates packages, drains, then reports each link.
module spill_sequencer
   import spill_sequencer_pkg::*;
#(
   parameter  int NLINK     = 4,
   parameter  int DRAIN_CYC = DRAIN_CYC_DEFAULT,
   localparam int LINK_W    = (NLINK > 1) ? $clog2(NLINK) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   live,
   input  logic                   spill_set,
   input  logic [SPILL_W-1:0]     spill_set_val,
   input  logic [NLINK-1:0]       pkg_valid,
   output logic                   live_rising,
   output logic [SPILL_W-1:0]     exp_spillno,
   output logic [NLINK-1:0]       get_package,
   input  logic [NLINK-1:0]       evtno_err,
   input  logic [NLINK-1:0]       spillno_err,
   input  logic [NLINK*EVT_W-1:0] in_counter,
   output logic                   rpt_valid,
   input  logic                   rpt_ready,
   output logic [LINK_W-1:0]      rpt_link,
   output logic                   rpt_evterr,
   output logic                   rpt_spillerr,
   output logic [EVT_W-1:0]       rpt_count,
   output logic                   spill_done,
   output logic                   overrun,
   output logic [7:0]             drop_cnt
);

   state_e             state_q;
   logic               live_q;
   logic [SPILL_W-1:0] next_q;
   logic [SPILL_W-1:0] exp_q;
   logic [15:0]        drain_q;
   logic [LINK_W-1:0]  idx_q;
   logic               pending_q;
   logic               overrun_q;
   logic [7:0]         drop_q;
   logic [7:0]         drop_d;
   logic [15:0]        drop_sum;
   logic               live_rising_q;
   logic               rpt_valid_q;
   logic               spill_done_q;
   logic               live_edge;
   logic               in_window;
   logic [NLINK-1:0]   evt_sticky;
   logic [NLINK-1:0]   spill_sticky;

   assign live_edge   = live & ~live_q;
   assign in_window   = (state_q == LIVE) || (state_q == DRAIN);
   assign get_package = in_window ? pkg_valid : '0;

   assign live_rising  = live_rising_q;
   assign exp_spillno  = exp_q;
   assign rpt_valid    = rpt_valid_q;
   assign rpt_link     = idx_q;
   assign rpt_evterr   = rpt_valid_q & evt_sticky[idx_q];
   assign rpt_spillerr = rpt_valid_q & spill_sticky[idx_q];
   assign rpt_count    = rpt_valid_q ? in_counter[idx_q*EVT_W +: EVT_W] : '0;
   assign spill_done   = spill_done_q;
   assign overrun      = overrun_q;
   assign drop_cnt     = drop_q;

   spill_err_collector #(
      .NLINK(NLINK)
   ) u_collector (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear_i       (state_q == ARM),
      .sample_en_i   (get_package),
      .evt_err_i     (evtno_err),
      .spill_err_i   (spillno_err),
      .evt_sticky_o  (evt_sticky),
      .spill_sticky_o(spill_sticky)
   );

   // Every asserted strobe outside the acceptance window counts once, saturating at 255.
   always_comb begin
      drop_sum = {8'd0, drop_q};
      if (!in_window) begin
         for (int i = 0; i < NLINK; i++) begin
            drop_sum = drop_sum + {15'd0, pkg_valid[i]};
         end
      end
      drop_d = (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         live_q        <= 1'b0;
         next_q        <= '0;
         exp_q         <= '0;
         drain_q       <= '0;
         idx_q         <= '0;
         pending_q     <= 1'b0;
         overrun_q     <= 1'b0;
         drop_q        <= '0;
         live_rising_q <= 1'b0;
         rpt_valid_q   <= 1'b0;
         spill_done_q  <= 1'b0;
      end else begin
         live_q        <= live;
         live_rising_q <= 1'b0;
         spill_done_q  <= 1'b0;
         drop_q        <= drop_d;
         case (state_q)
            IDLE: begin
               if (spill_set) begin
                  next_q <= spill_set_val;
               end
               if (live_edge) begin
                  state_q       <= ARM;
                  live_rising_q <= 1'b1;
               end
            end
            ARM: begin
               exp_q     <= next_q;
               next_q    <= next_q + 1'b1;
               pending_q <= 1'b0;
               state_q   <= LIVE;
            end
            LIVE: begin
               if (live_edge) begin
                  overrun_q <= 1'b1;
                  pending_q <= 1'b1;
               end
               if (!live) begin
                  state_q <= DRAIN;
                  drain_q <= 16'(DRAIN_CYC);
               end
            end
            DRAIN: begin
               // A new spill starting mid-drain cuts the drain short.
               if (live_edge || drain_q == 16'd1) begin
                  if (live_edge) begin
                     overrun_q <= 1'b1;
                     pending_q <= 1'b1;
                  end
                  state_q     <= REPORT;
                  rpt_valid_q <= 1'b1;
                  idx_q       <= '0;
               end else begin
                  drain_q <= drain_q - 16'd1;
               end
            end
            REPORT: begin
               if (live_edge) begin
                  overrun_q <= 1'b1;
                  pending_q <= 1'b1;
               end
               if (rpt_ready) begin
                  if (idx_q == LINK_W'(NLINK - 1)) begin
                     rpt_valid_q  <= 1'b0;
                     idx_q        <= '0;
                     spill_done_q <= 1'b1;
                     if (pending_q || live_edge) begin
                        state_q       <= ARM;
                        live_rising_q <= 1'b1;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
